// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch-address consumer and instruction queue.
// Takes addresses from the PC stage, issues single-cycle instruction memory
// reads, and queues {pc, instr} pairs in program order for decode.
// Credits are taken from registered state only (occupancy + in-flight read),
// so there is no combinational path from out_ready to addr_ready.
module ifetch_queue #(
  parameter int FULLW = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             addr_valid,
  input  logic [FULLW-1:0] addr,
  output logic             addr_ready,
  output logic             imem_req,
  output logic [FULLW-1:0] imem_addr,
  input  logic [FULLW-1:0] imem_rdata,
  input  logic             flush,
  output logic             out_valid,
  output logic [FULLW-1:0] out_pc,
  output logic [FULLW-1:0] out_instr,
  input  logic             out_ready,
  output logic             misalign
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [FULLW-1:0] pc_mem_q    [DEPTH];
  logic [FULLW-1:0] instr_mem_q [DEPTH];

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [FULLW-1:0] inflight_pc_q, inflight_pc_d;
  logic             misalign_q, misalign_d;
  logic             ready_en_q;

  logic [CW-1:0]    credits;
  logic             accept;
  logic             push;
  logic             pop;

  // ready_en_q keeps addr_ready low while in reset and for the release cycle.
  assign credits    = CW'(occ_q) + CW'(inflight_q);
  assign addr_ready = ready_en_q && (credits < DEPTH_C) && !flush;
  assign accept     = addr_valid && addr_ready;

  assign imem_req   = accept;
  assign imem_addr  = accept ? addr : '0;

  // A response arriving during a flush cycle belongs to a pre-flush request
  // and is dropped; no request can be issued in the flush cycle itself, so
  // nothing stale can arrive afterwards.
  assign push       = inflight_q && !flush;
  assign pop        = (occ_q != '0) && out_ready && !flush;

  assign out_valid  = (occ_q != '0);
  assign out_pc     = pc_mem_q[rd_ptr_q];
  assign out_instr  = instr_mem_q[rd_ptr_q];
  assign misalign   = misalign_q;

  // Next-state for pointers, occupancy, in-flight tracking and sticky misalign.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    inflight_d    = accept;
    inflight_pc_d = accept ? addr : inflight_pc_q;
    misalign_d    = misalign_q || (accept && (addr[1:0] != 2'b00));

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      misalign_q    <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misalign_q    <= misalign_d;
      ready_en_q    <= 1'b1;
    end
  end

  // Queue storage: the returning read data is written with its pc at the tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized and directed checks of ifetch_queue against a
// queue-level reference model of the fetch queue behaviour.
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        addr_valid = 1'b0;
  logic [31:0] addr = '0;
  logic        addr_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic        misalign;

  ifetch_queue #(.FULLW(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr_valid (addr_valid),
    .addr       (addr),
    .addr_ready (addr_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_ready  (out_ready),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [31:0] m_q[$];
  int          m_infl = 0;
  logic [31:0] m_infl_pc = '0;
  logic        m_mis = 1'b0;

  // memory responder state
  logic        resp_pend = 1'b0;
  logic [31:0] resp_addr = '0;

  // observed event counters
  int          n_acc_obs = 0;
  int          n_pop_obs = 0;
  logic [31:0] first_pop = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model.
  task automatic step(input logic av, input logic [31:0] a, input logic fl, input logic ordy);
    int   occ;
    logic exp_rdy;
    logic exp_acc;
    @(posedge clk);
    #1;
    addr_valid = av;
    addr       = a;
    flush      = fl;
    out_ready  = ordy;
    imem_rdata = resp_pend ? instr_of(resp_addr) : 32'hDEAD_BEEF;
    #4;
    occ     = m_q.size();
    exp_rdy = (occ + m_infl < DEPTH) && !fl;
    exp_acc = av && exp_rdy;
    chk("addr_ready", 32'(addr_ready), 32'(exp_rdy));
    chk("imem_req", 32'(imem_req), 32'(exp_acc));
    chk("imem_addr", imem_addr, exp_acc ? a : 32'h0);
    chk("out_valid", 32'(out_valid), 32'(occ != 0));
    if (occ != 0) begin
      chk("out_pc", out_pc, m_q[0]);
      chk("out_instr", out_instr, instr_of(m_q[0]));
    end
    chk("misalign", 32'(misalign), 32'(m_mis));

    if (av && addr_ready) n_acc_obs++;
    if (out_valid && ordy && !fl) begin
      if (n_pop_obs == 0) first_pop = out_pc;
      n_pop_obs++;
    end
    resp_pend = imem_req;
    resp_addr = imem_addr;

    if (fl) begin
      m_q.delete();
      m_infl = 0;
    end else begin
      if (occ != 0 && ordy) void'(m_q.pop_front());
      if (m_infl != 0) m_q.push_back(m_infl_pc);
      m_infl    = exp_acc ? 1 : 0;
      m_infl_pc = a;
      if (exp_acc && a[1:0] != 2'b00) m_mis = 1'b1;
    end
    if (m_q.size() > DEPTH) begin
      n_checks++;
      n_err++;
      $display("FAIL overflow: got %0d entries limit %0d", m_q.size(), DEPTH);
    end
  endtask

  // Pulse reset mid-cycle with a fetch offered; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n    = 1'b0;
    addr_valid = 1'b1;
    addr       = 32'h300;
    #1;
    chk("rst_addr_ready", 32'(addr_ready), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    addr_valid = 1'b0;
    addr       = '0;
    flush      = 1'b0;
    m_q.delete();
    m_infl    = 0;
    m_mis     = 1'b0;
    resp_pend = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic        rav, rfl, rrdy;

    do_reset();

    // 1: back-to-back fetches 0,4,8,12 with decode always ready
    n_pop_obs = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t1_pops", 32'(n_pop_obs), 32'd4);
    chk("t1_first_pc", first_pop, 32'h0);

    // 2: stalled decode, exactly DEPTH accepts, then drain in order
    n_acc_obs = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
    chk("t2_accepts", 32'(n_acc_obs), 32'(DEPTH));
    n_pop_obs = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 32'h2000 + 32'(i * 4), 1'b0, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t2_first_pc", first_pop, 32'h1000);
    chk("t2_drained", 32'(out_valid), 32'h0);

    // 3: flush with two entries queued and 0x20 in flight
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h14, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h24, 1'b1, 1'b1);
    n_pop_obs = 0;
    step(1'b1, 32'h80, 1'b0, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t3_first_after_flush", first_pop, 32'h80);
    chk("t3_pops", 32'(n_pop_obs), 32'd1);

    // 4: random valid/ready/flush, 1000 accepted addresses
    n_acc_obs = 0;
    for (int cyc = 0; cyc < 20000 && n_acc_obs < 1000; cyc++) begin
      rav  = ($urandom_range(0, 99) < 70);
      rrdy = ($urandom_range(0, 99) < 60);
      rfl  = ($urandom_range(0, 99) < 2);
      ra   = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      step(rav, ra, rfl, rrdy);
    end
    chk("t4_accepted", 32'(n_acc_obs >= 1000), 32'h1);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);

    // 5: misaligned fetch is issued and sets the sticky flag; reset clears it
    step(1'b1, 32'h6, 1'b0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t5_misalign_sticky", 32'(misalign), 32'h1);
    step(1'b1, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h408, 1'b0, 1'b0);
    do_reset();
    n_pop_obs = 0;
    step(1'b1, 32'h500, 1'b0, 1'b1);
    step(1'b1, 32'h504, 1'b0, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t5_post_reset_first", first_pop, 32'h500);
    chk("t5_post_reset_pops", 32'(n_pop_obs), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
